// File: rtl/time_counter.sv
// time_counter: BCD hh:mm:ss timekeeper driven by a 1 Hz square wave sampled
// in the clk_in domain. A button FSM sets the hour and minute fields.
//
// Optional feature macro: ALARM_EN. When it is defined the block adds BCD
// alarm hour/minute registers, two more set states, and the alarm ports.
//
// Ports:
//   clk_in     in   1 kHz system clock
//   rst_n      in   asynchronous reset, active low
//   clk_1hz    in   1 Hz square wave from the divider (clk_in domain)
//   btn_mode   in   1-cycle pulse, advances mode
//   btn_inc    in   1-cycle pulse, increments the selected field
//   alarm_en   in   alarm enable (ALARM_EN only)
//   hour_bcd   out  {tens,units} BCD hour
//   min_bcd    out  {tens,units} BCD minute
//   sec_bcd    out  {tens,units} BCD second
//   mode       out  0=RUN 1=SET_HR 2=SET_MIN (3=SET_AL_HR 4=SET_AL_MIN)
//   tick_1s    out  1-cycle pulse, high when a second was counted
//   alarm_ring out  high while the alarm time matches (ALARM_EN only)
module time_counter #(
  parameter int unsigned HOURS      = 24,
  parameter int unsigned HOUR_RESET = 0
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       clk_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
`ifdef ALARM_EN
  input  logic       alarm_en,
  output logic       alarm_ring,
`endif
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [2:0] mode,
  output logic       tick_1s
);

  localparam logic [7:0] HOUR_MAX_BCD   = {4'((HOURS - 1) / 10), 4'((HOURS - 1) % 10)};
  localparam logic [7:0] HOUR_RESET_BCD = {4'(HOUR_RESET / 10), 4'(HOUR_RESET % 10)};
  localparam logic [7:0] MIN_SEC_MAX    = 8'h59;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    SET_HR     = 3'd1,
    SET_MIN    = 3'd2,
    SET_AL_HR  = 3'd3,
    SET_AL_MIN = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic       clk_1hz_d;
  logic       tick_c;
  logic [7:0] hour_d, min_d, sec_d;
  logic       tick_d;
`ifdef ALARM_EN
  logic [7:0] al_hr_q, al_min_q, al_hr_d, al_min_d;
`endif

  // BCD increment with wrap to 00 once the field reaches its maximum
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Rising edge of the 1 Hz wave; acted on at the same edge that samples it
  assign tick_c = clk_1hz & ~clk_1hz_d;
  assign mode   = 3'(state_q);

  // Next-state and field update; btn_mode takes priority over inc and tick
  always_comb begin
    state_d = state_q;
    hour_d  = hour_bcd;
    min_d   = min_bcd;
    sec_d   = sec_bcd;
    tick_d  = 1'b0;
`ifdef ALARM_EN
    al_hr_d  = al_hr_q;
    al_min_d = al_min_q;
`endif
    if (btn_mode) begin
      case (state_q)
        RUN: begin
          state_d = SET_HR;
          sec_d   = 8'h00;
        end
        SET_HR:  state_d = SET_MIN;
`ifdef ALARM_EN
        SET_MIN:   state_d = SET_AL_HR;
        SET_AL_HR: state_d = SET_AL_MIN;
`endif
        default: state_d = RUN;
      endcase
    end else begin
      case (state_q)
        RUN: begin
          if (tick_c) begin
            tick_d = 1'b1;
            sec_d  = bcd_inc(sec_bcd, MIN_SEC_MAX);
            if (sec_bcd == MIN_SEC_MAX) begin
              min_d = bcd_inc(min_bcd, MIN_SEC_MAX);
              if (min_bcd == MIN_SEC_MAX)
                hour_d = bcd_inc(hour_bcd, HOUR_MAX_BCD);
            end
          end
        end
        SET_HR:  if (btn_inc) hour_d = bcd_inc(hour_bcd, HOUR_MAX_BCD);
        SET_MIN: if (btn_inc) min_d = bcd_inc(min_bcd, MIN_SEC_MAX);
`ifdef ALARM_EN
        SET_AL_HR:  if (btn_inc) al_hr_d = bcd_inc(al_hr_q, HOUR_MAX_BCD);
        SET_AL_MIN: if (btn_inc) al_min_d = bcd_inc(al_min_q, MIN_SEC_MAX);
`endif
        default: ;
      endcase
    end
  end

  // State and time registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      clk_1hz_d <= 1'b0;
      hour_bcd  <= HOUR_RESET_BCD;
      min_bcd   <= 8'h00;
      sec_bcd   <= 8'h00;
      tick_1s   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_1hz_d <= clk_1hz;
      hour_bcd  <= hour_d;
      min_bcd   <= min_d;
      sec_bcd   <= sec_d;
      tick_1s   <= tick_d;
    end
  end

`ifdef ALARM_EN
  // Alarm registers; ring compares the current registered time
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      al_hr_q    <= 8'h00;
      al_min_q   <= 8'h00;
      alarm_ring <= 1'b0;
    end else begin
      al_hr_q    <= al_hr_d;
      al_min_q   <= al_min_d;
      alarm_ring <= (state_q == RUN) && alarm_en &&
                    (hour_bcd == al_hr_q) && (min_bcd == al_min_q);
    end
  end
`endif

endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: directed checks of time_counter counting, carries, set
// FSM, simultaneous button/tick events, async reset and (optionally) alarm.
module tb_time_counter;

  logic       clk_in, rst_n, clk_1hz, btn_mode, btn_inc;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic [2:0] mode;
  logic       tick_1s;
`ifdef ALARM_EN
  logic       alarm_en, alarm_ring;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int tick_cnt = 0;
  int tick_wide = 0;
  logic tick_prev = 1'b0;
  int cnt0;

  time_counter #(.HOURS(24), .HOUR_RESET(0)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .clk_1hz  (clk_1hz),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
`ifdef ALARM_EN
    .alarm_en   (alarm_en),
    .alarm_ring (alarm_ring),
`endif
    .hour_bcd (hour_bcd),
    .min_bcd  (min_bcd),
    .sec_bcd  (sec_bcd),
    .mode     (mode),
    .tick_1s  (tick_1s)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Count tick pulses and any pulse longer than one cycle
  always @(negedge clk_in) begin
    if (tick_1s) begin
      tick_cnt = tick_cnt + 1;
      if (tick_prev) tick_wide = tick_wide + 1;
    end
    tick_prev = tick_1s;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] s);
    check({tag, ".hour"}, 32'(hour_bcd), 32'(h));
    check({tag, ".min"},  32'(min_bcd),  32'(m));
    check({tag, ".sec"},  32'(sec_bcd),  32'(s));
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic rises(input int n, input int half);
    for (int i = 0; i < n; i++) begin
      clk_1hz = 1'b1;
      repeat (half) step();
      clk_1hz = 1'b0;
      repeat (half) step();
    end
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) press(1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; clk_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
`ifdef ALARM_EN
    alarm_en = 1'b0;
`endif
    repeat (3) step();
    check_time("reset", 8'h00, 8'h00, 8'h00);
    check("reset.mode", 32'(mode), 32'd0);
    check("reset.tick", 32'(tick_1s), 32'd0);
    rst_n = 1'b1;
    repeat (3) step();

    // 1: 60 rises -> 00:01:00, one-cycle ticks, zero latency
    cnt0 = tick_cnt;
    clk_1hz = 1'b1;
    step();
    check("t1.first_tick", 32'(tick_1s), 32'd1);
    check("t1.first_sec", 32'(sec_bcd), 32'h01);
    step();
    check("t1.held_no_tick", 32'(tick_1s), 32'd0);
    check("t1.held_sec", 32'(sec_bcd), 32'h01);
    clk_1hz = 1'b0;
    repeat (18) step();
    rises(59, 20);
    check_time("t1.end", 8'h00, 8'h01, 8'h00);
    check("t1.tick_count", 32'(tick_cnt - cnt0), 32'd60);
    check("t1.tick_width", 32'(tick_wide), 32'd0);

    // 2: set 23:59, count to 23:59:59 then roll to 00:00:00
    press(1'b1, 1'b0);
    check("t2.mode_sethr", 32'(mode), 32'd1);
    incs(23);
    press(1'b1, 1'b0);
    check("t2.mode_setmin", 32'(mode), 32'd2);
    incs(58);
    press(1'b1, 1'b0);
    check("t2.mode_run", 32'(mode), 32'd0);
    check_time("t2.set", 8'h23, 8'h59, 8'h00);
    rises(59, 5);
    check_time("t2.pre_wrap", 8'h23, 8'h59, 8'h59);
    clk_1hz = 1'b1;
    step();
    check_time("t2.wrap", 8'h00, 8'h00, 8'h00);
    check("t2.wrap_tick", 32'(tick_1s), 32'd1);
    clk_1hz = 1'b0;
    repeat (5) step();

    // 3: mode press coincident with tick at 00:00:37, then set hour
    rises(37, 5);
    check_time("t3.start", 8'h00, 8'h00, 8'h37);
    clk_1hz = 1'b1;
    press(1'b1, 1'b0);
    check("t3.mode", 32'(mode), 32'd1);
    check("t3.sec_clr", 32'(sec_bcd), 32'h00);
    check("t3.tick_drop", 32'(tick_1s), 32'd0);
    clk_1hz = 1'b0;
    step();
    cnt0 = tick_cnt;
    rises(5, 5);
    check_time("t3.frozen", 8'h00, 8'h00, 8'h00);
    check("t3.no_ticks", 32'(tick_cnt - cnt0), 32'd0);
    incs(25);
    check("t3.hour_wrap", 32'(hour_bcd), 32'h01);

    // 4: minute wrap without carry, mode+inc together, inc ignored in RUN
    press(1'b1, 1'b0);
    incs(59);
    check("t4.min59", 32'(min_bcd), 32'h59);
    incs(1);
    check_time("t4.min_wrap", 8'h01, 8'h00, 8'h00);
    incs(59);
    press(1'b1, 1'b1);
    check("t4.mode_run", 32'(mode), 32'd0);
    check("t4.inc_dropped", 32'(min_bcd), 32'h59);
    press(1'b0, 1'b1);
    check_time("t4.run_inc", 8'h01, 8'h59, 8'h00);

    // 5: async reset mid-cycle at 12:34:56
    press(1'b1, 1'b0);
    incs(11);
    press(1'b1, 1'b0);
    incs(35);
    press(1'b1, 1'b0);
    rises(56, 5);
    check_time("t5.pre", 8'h12, 8'h34, 8'h56);
    @(posedge clk_in);
    #2;
    clk_1hz = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_time("t5.async", 8'h00, 8'h00, 8'h00);
    check("t5.mode", 32'(mode), 32'd0);
    check("t5.tick", 32'(tick_1s), 32'd0);
    clk_1hz = 1'b0;
    step();
    rst_n = 1'b1;
    step();

`ifdef ALARM_EN
    // 6: alarm at 07:30 starting from 07:29:59
    press(1'b1, 1'b0); incs(7);
    press(1'b1, 1'b0); incs(29);
    press(1'b1, 1'b0); incs(7);
    press(1'b1, 1'b0); incs(30);
    press(1'b1, 1'b0);
    check("t6.mode_run", 32'(mode), 32'd0);
    alarm_en = 1'b1;
    rises(59, 5);
    check_time("t6.pre", 8'h07, 8'h29, 8'h59);
    check("t6.ring_pre", 32'(alarm_ring), 32'd0);
    clk_1hz = 1'b1;
    step();
    check("t6.ring_same", 32'(alarm_ring), 32'd0);
    step();
    check("t6.ring_on", 32'(alarm_ring), 32'd1);
    alarm_en = 1'b0;
    step();
    check("t6.ring_en_off", 32'(alarm_ring), 32'd0);
    alarm_en = 1'b1;
    step();
    check("t6.ring_en_on", 32'(alarm_ring), 32'd1);
    clk_1hz = 1'b0;
    repeat (5) step();
    rises(60, 5);
    check_time("t6.next_min", 8'h07, 8'h31, 8'h00);
    step();
    check("t6.ring_off", 32'(alarm_ring), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
